// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl
//   Single-clock FIFO controller driving one simple dual-port RAM that has a
//   registered, rd_en-gated read port. The RAM read register doubles as the
//   first-word-fall-through output stage, so capacity is RAM_DEPTH + 1 words.
//
// Optional feature:
//   MEM_FIFO_CTRL_FLUSH_EN - adds input 'flush'; a flush cycle empties the FIFO
//   (rst_n still has priority). Without the macro the flush path is absent.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     producer handshake, in_data producer word
//   out_valid/out_ready   consumer handshake, out_data head word (= mem_rdata)
//   mem_wdata/waddr/wr_en RAM write port
//   mem_raddr/rd_en       RAM read port, mem_rdata RAM read register output
//   level                 words held (RAM entries + output stage)
//
// Output stage states:
//   state     | meaning
//   OUT_EMPTY | RAM read register holds no valid word (out_valid=0)
//   OUT_FULL  | RAM read register holds the head word (out_valid=1)

module mem_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int RAM_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef MEM_FIFO_CTRL_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH:0]   level
);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    out_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;

    logic flush_w;
    logic active;
    logic wr_fire;
    logic fetch;

`ifdef MEM_FIFO_CTRL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Reset and flush both block all RAM traffic in the cycle they are applied.
    assign active    = rst_n & ~flush_w;

    // Full is judged on the registered count only; a same-cycle fetch does not
    // free a slot for the producer.
    assign in_ready  = active & (ram_cnt_q != DEPTH_C);
    assign wr_fire   = in_valid & in_ready;

    // Fetch refills the read register whenever it is empty or being drained.
    assign out_valid = (state_q == OUT_FULL);
    assign fetch     = active & (ram_cnt_q != '0) & (~out_valid | out_ready);

    assign mem_wdata = in_data;
    assign mem_waddr = wptr_q;
    assign mem_wr_en = wr_fire;
    assign mem_raddr = rptr_q;
    assign mem_rd_en = fetch;
    assign out_data  = mem_rdata;

    assign level     = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, out_valid};

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;

        if (wr_fire) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (fetch) begin
            rptr_d = rptr_q + PTR_ONE;
        end

        case ({wr_fire, fetch})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        case (state_q)
            OUT_EMPTY: begin
                if (fetch) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready && !fetch) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    // RAM contents are deliberately left untouched; only the bookkeeping is
    // cleared, which discards every held word.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_w) begin
            state_q   <= OUT_EMPTY;
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
module tb_mem_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] mem_wdata;
    logic [1:0] mem_waddr;
    logic       mem_wr_en;
    logic [1:0] mem_raddr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .RAM_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MEM_FIFO_CTRL_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem_wdata (mem_wdata),
        .mem_waddr (mem_waddr),
        .mem_wr_en (mem_wr_en),
        .mem_raddr (mem_raddr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .level     (level)
    );

    // Simple dual-port RAM with registered, rd_en-gated read
    logic [7:0] ram [0:3];
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_waddr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: words in RAM as a queue, plus the presented head word.
    logic [7:0] m_ram[$];
    bit         m_ov = 1'b0;
    logic [7:0] m_od;
    bit         m_act, m_in_ready, m_fetch, m_acc;

    initial begin
        forever begin
            @(negedge clk);
            m_act      = rst_n && !flush;
            m_in_ready = m_act && (m_ram.size() < 4);
            m_fetch    = m_act && (m_ram.size() != 0) && (!m_ov || out_ready);
            m_acc      = in_valid && m_in_ready;
            check("m_in_ready", 32'(in_ready), 32'(m_in_ready));
            check("m_out_valid", 32'(out_valid), 32'(m_ov));
            check("m_level", 32'(level), 32'(m_ram.size() + int'(m_ov)));
            check("m_wr_en", 32'(mem_wr_en), 32'(m_acc));
            check("m_rd_en", 32'(mem_rd_en), 32'(m_fetch));
            if (m_ov) check("m_out_data", 32'(out_data), 32'(m_od));
            @(posedge clk);
            if (!rst_n || flush) begin
                m_ram.delete();
                m_ov = 1'b0;
            end else begin
                if (m_fetch) begin
                    m_od = m_ram.pop_front();
                    m_ov = 1'b1;
                end else if (m_ov && out_ready) begin
                    m_ov = 1'b0;
                end
                if (m_acc) m_ram.push_back(in_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc;
        int         sent;
        int         got;
        int         first_cyc;
        int         last_cyc;
        bit         seen;
        logic [7:0] rx[$];
        logic [7:0] sb[$];
        logic [7:0] w;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;

        // ---- Reset and single word 0xA5 ----
        tick(); tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        tick(); rst_n = 1'b1;                       // cycle 0
        @(negedge clk);
        check("t1_level0", 32'(level), 32'd0);
        check("t1_ov0", 32'(out_valid), 32'd0);
        tick(); in_valid = 1'b1; in_data = 8'hA5;   // cycle 1
        @(negedge clk);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0;                    // cycle 2
        @(negedge clk);
        check("t1_level_c2", 32'(level), 32'd1);
        check("t1_ov_c2", 32'(out_valid), 32'd0);
        tick();                                     // cycle 3
        @(negedge clk);
        check("t1_ov_c3", 32'(out_valid), 32'd1);
        check("t1_data_c3", 32'(out_data), 32'hA5);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("t1_hold_valid", 32'(out_valid), 32'd1);
            check("t1_hold_data", 32'(out_data), 32'hA5);
        end
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;

        // ---- Fill to capacity, then drain ----
        in_valid = 1'b1; in_data = 8'h01; acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            tick();
            in_data = 8'(acc + 1);
        end
        check("t2_accepted", 32'(acc), 32'd5);
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_level", 32'(level), 32'd5);
        check("t2_in_ready", 32'(in_ready), 32'd0);
        tick(); out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2_drain_valid", 32'(out_valid), (i < 5) ? 32'd1 : 32'd0);
            if (i < 5) check("t2_drain_data", 32'(out_data), 32'(i + 1));
            tick();
        end
        out_ready = 1'b0;

        // ---- Streaming 64 words ----
        rx.delete(); seen = 1'b0; first_cyc = 0; last_cyc = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            in_data  = 8'(i);
            in_valid = (i < 64);
            @(negedge clk);
            if (i < 64) check("t3_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2 && i < 64) check("t3_level", 32'(level), 32'd2);
            if (out_valid && out_ready) begin
                if (!seen) first_cyc = i;
                seen = 1'b1;
                last_cyc = i;
                rx.push_back(out_data);
            end
            tick();
        end
        check("t3_count", 32'(rx.size()), 32'd64);
        check("t3_first_cycle", 32'(first_cyc), 32'd2);
        check("t3_no_gaps", 32'(last_cyc - first_cyc), 32'd63);
        for (int i = 0; i < rx.size(); i++) check("t3_order", 32'(rx[i]), 32'(i));
        in_valid = 1'b0; out_ready = 1'b0;

        // ---- Random traffic, 2000 words ----
        sb.delete(); sent = 0; got = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (sent >= 2000 && got >= 2000) break;
            in_valid  = (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            @(negedge clk);
            check("t4_level", 32'(level), 32'(sent - got));
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("t4_underflow", 32'd1, 32'd0);
                end else begin
                    w = sb.pop_front();
                    check("t4_order", 32'(out_data), 32'(w));
                end
                got++;
            end
            tick();
        end
        check("t4_delivered", 32'(got), 32'd2000);
        in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // ---- Reset with level 3 ----
        in_valid = 1'b1; in_data = 8'h11;
        tick(); in_data = 8'h22;
        tick(); in_data = 8'h33;
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("t5_level3", 32'(level), 32'd3);
        tick(); rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_in_ready", 32'(in_ready), 32'd0);
        check("t5_rst_rd_en", 32'(mem_rd_en), 32'd0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        check("t5_level0", 32'(level), 32'd0);
        check("t5_ov0", 32'(out_valid), 32'd0);
        tick(); in_valid = 1'b1; in_data = 8'h3C;
        tick(); in_valid = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check("t5_first_word", 32'(out_data), 32'h3C);
            end
            tick();
        end
        check("t5_word_seen", 32'(seen), 32'd1);
        out_ready = 1'b0;
        tick();

`ifdef MEM_FIFO_CTRL_FLUSH_EN
        // ---- Flush with level 4 ----
        in_valid = 1'b1; in_data = 8'h40;
        tick(); in_data = 8'h41;
        tick(); in_data = 8'h42;
        tick(); in_data = 8'h43;
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("t6_level4", 32'(level), 32'd4);
        tick(); flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk);
        check("t6_flush_in_ready", 32'(in_ready), 32'd0);
        check("t6_flush_wr_en", 32'(mem_wr_en), 32'd0);
        check("t6_flush_rd_en", 32'(mem_rd_en), 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t6_level0", 32'(level), 32'd0);
        tick(); in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        check("t6_accept", 32'(in_ready), 32'd1);
        tick(); in_valid = 1'b0;
        @(negedge clk);
        check("t6_ov_c1", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t6_ov_c2", 32'(out_valid), 32'd1);
        check("t6_data_c2", 32'(out_data), 32'h77);
        tick();
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_fifo_ctrl.md
Name: mem_fifo_ctrl

Overview:
- Single-clock FIFO controller that sequences one instance of the team's simple dual-port RAM (registered read, `rd_en`-gated read register), with both RAM clock ports tied to `clk`.
- Generates write/read addresses and enables, and tracks occupancy.
- Presents valid/ready streaming interfaces on both sides with first-word-fall-through output.
- Sits between MIPI pixel-path producers and consumers as the standard elastic buffer.

Parameters:
- DATA_WIDTH, 8, word width; must match RAM DATA_WIDTH
- ADDR_WIDTH, 2, RAM address width
- RAM_DEPTH, 4, RAM entries; must equal 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock; drives both RAM clock ports
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  controller accepts a word this cycle
- in_data  input  DATA_WIDTH  producer word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer takes the word this cycle
- out_data  output  DATA_WIDTH  head word; wired directly from mem_rdata
- mem_wdata  output  DATA_WIDTH  to RAM wdata; equals in_data
- mem_waddr  output  ADDR_WIDTH  to RAM waddr; equals wptr
- mem_wr_en  output  1  to RAM wr_en
- mem_raddr  output  ADDR_WIDTH  to RAM raddr; equals rptr
- mem_rd_en  output  1  to RAM rd_en
- mem_rdata  input  DATA_WIDTH  from RAM rdata
- level  output  ADDR_WIDTH+1  words held: ram_cnt + out_valid

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is synchronous and active-low.
- Reset state (rst_n=0 at a clk edge): wptr=0, rptr=0, ram_cnt=0, out_valid=0, level=0.
- While rst_n=0: in_ready=0, mem_wr_en=0, mem_rd_en=0, all combinationally.
- RAM contents are not cleared.
- Reset mid-operation discards all held words; the next accepted word after reset is the first word out.
- Write side:
  - in_ready = rst_n & (ram_cnt != RAM_DEPTH). Registered count only; no same-cycle bypass from a read.
  - wr_fire = in_valid & in_ready. mem_wr_en = wr_fire.
  - On wr_fire, wptr increments, wrapping modulo RAM_DEPTH.
- Read/fetch side, with output FSM states OUT_EMPTY (out_valid=0) and OUT_FULL (out_valid=1):
  - fetch = rst_n & (ram_cnt != 0) & (!out_valid | out_ready). mem_rd_en = fetch.
  - On fetch, rptr increments (wrapping) and out_valid becomes 1 next cycle. The RAM read register holds mem_rdata when rd_en=0, so out_data is stable while out_valid & !out_ready.
  - OUT_EMPTY -> OUT_FULL on fetch.
  - OUT_FULL -> OUT_EMPTY on out_ready & !fetch.
  - OUT_FULL stays OUT_FULL on fetch, or on !out_ready.
- ram_cnt next value = ram_cnt + wr_fire − fetch. Width ADDR_WIDTH+1. It never exceeds RAM_DEPTH and never underflows.
- Simultaneous wr_fire and fetch: ram_cnt unchanged, both pointers advance.
- No read-during-write hazard: a word written at edge N is first fetchable in cycle N+1 (ram_cnt updates at edge N).
- Latency: in_data accepted in cycle N to out_valid=1 in cycle N+2 when the FIFO was empty.
- Throughput: 1 word/cycle sustained on both sides.
- Capacity: RAM_DEPTH+1 words (RAM plus the RAM read register).
- out_data is undefined while out_valid=0.

Optional Feature:
- Macro: MEM_FIFO_CTRL_FLUSH_EN
- Defined:
  - Adds input port `flush` (1 bit).
  - flush=1 at a clk edge applies the reset state to wptr, rptr, ram_cnt and out_valid.
  - During a flush cycle: in_ready=0, mem_wr_en=0, mem_rd_en=0.
  - rst_n has priority over flush.
- Undefined: no `flush` port; logic is identical to a flush tied to 0.

Test Plan:
- Reset, then one write of 0xA5 in cycle 1 with out_ready=0: out_valid rises in cycle 3 with out_data=0xA5; level=1 in cycle 2; out_data holds 0xA5 for 10 cycles with out_ready=0.
- Fill with out_ready=0 and in_valid=1 continuously (RAM_DEPTH=4), words 0x01..0x06: in_ready drops after 5 accepted words (level=5); 0x06 is not accepted. Release out_ready=1: reads 0x01..0x05 in order, one per cycle, with no bubbles.
- Streaming 64 incrementing words, in_valid=out_ready=1 throughout: output sequence 0..63 with no gaps after initial 2-cycle latency; level constant at 2; pointers wrap 16 times.
- Random in_valid/out_ready at 50% each, 2000 words: output equals input order; level always equals accepted minus delivered; no mem_wr_en while ram_cnt=4; no mem_rd_en while ram_cnt=0.
- Assert rst_n=0 for one cycle with level=3: level=0 and out_valid=0 next cycle; a following write of 0x3C is the first word delivered.
- Flush (MEM_FIFO_CTRL_FLUSH_EN defined), flush=1 with level=4 and in_valid=1: in_ready=0 that cycle; level=0 next cycle; the next word 0x77 emerges 2 cycles after acceptance.
